// File: rtl/alu_v_cntrl.sv
// RISC-V ALU control decoder: maps ALUOp plus {funct7[5], funct3} to a registered
// 4-bit ALU operation select.
module alu_v_cntrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ALUOp,
   input  logic [3:0] func,
   output logic [3:0] ALUCtrl
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
   localparam logic [3:0] OP_NIL  = 4'b1111;

   logic [3:0] alu_ctrl_d;
   logic [3:0] alu_ctrl_q;

   // funct7[5] only distinguishes ADD/SUB and SRL/SRA; it is ignored elsewhere.
   always_comb begin
      alu_ctrl_d = OP_NIL;
      case (ALUOp)
         2'b00: alu_ctrl_d = OP_ADD;
         2'b01: alu_ctrl_d = OP_SUB;
         2'b10: begin
            case (func[2:0])
               3'b000:  alu_ctrl_d = func[3] ? OP_SUB : OP_ADD;
               3'b001:  alu_ctrl_d = OP_SLL;
               3'b010:  alu_ctrl_d = OP_SLT;
               3'b011:  alu_ctrl_d = OP_SLTU;
               3'b100:  alu_ctrl_d = OP_XOR;
               3'b101:  alu_ctrl_d = func[3] ? OP_SRA : OP_SRL;
               3'b110:  alu_ctrl_d = OP_OR;
               default: alu_ctrl_d = OP_AND;
            endcase
         end
         default: alu_ctrl_d = OP_NIL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_ctrl_q <= OP_NIL;
      end else begin
         alu_ctrl_q <= alu_ctrl_d;
      end
   end

   assign ALUCtrl = alu_ctrl_q;

endmodule

// File: tb/tb_alu_v_cntrl.sv
// Self-checking bench for alu_v_cntrl: vector table plus reset and hold sequences,
// with expected codes queued at drive time and popped when the output is sampled.
module tb_alu_v_cntrl;

   logic       clk;
   logic       rst;
   logic [1:0] ALUOp;
   logic [3:0] func;
   logic [3:0] ALUCtrl;

   typedef struct {
      logic [1:0] op;
      logic [3:0] fn;
      logic [3:0] exp;
      string      name;
   } vec_t;

   vec_t       vecs[$];
   logic [3:0] expQ[$];
   string      nameQ[$];
   int         checks;
   int         errors;
   logic [3:0] sweepExp;

   alu_v_cntrl dut (
      .clk    (clk),
      .rst    (rst),
      .ALUOp  (ALUOp),
      .func   (func),
      .ALUCtrl(ALUCtrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one input pair at the falling edge and queue the decode expected after
   // the next rising edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] fn,
                                input logic [3:0] exp, input string name);
      @(negedge clk);
      ALUOp = op;
      func  = fn;
      expQ.push_back(exp);
      nameQ.push_back(name);
   endtask

   task automatic checkValue(input string name, input logic [3:0] exp);
      checks++;
      if (ALUCtrl !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", name, ALUCtrl, exp);
      end
   endtask

   // Wait past the rising edge and compare against the oldest queued expectation.
   task automatic checkOutput();
      logic [3:0] exp;
      string      name;
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got %b expected a queued value", ALUCtrl);
      end else begin
         exp  = expQ.pop_front();
         name = nameQ.pop_front();
         checkValue(name, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vecs.push_back('{2'b10, 4'b0000, 4'b0010, "rtype_add"});
      vecs.push_back('{2'b10, 4'b1000, 4'b0110, "rtype_sub"});
      vecs.push_back('{2'b10, 4'b0110, 4'b0001, "rtype_or"});
      vecs.push_back('{2'b10, 4'b0111, 4'b0000, "rtype_and"});
      vecs.push_back('{2'b10, 4'b0001, 4'b0011, "rtype_sll"});
      vecs.push_back('{2'b10, 4'b0010, 4'b0111, "rtype_slt"});
      vecs.push_back('{2'b10, 4'b0011, 4'b1000, "rtype_sltu"});
      vecs.push_back('{2'b10, 4'b0100, 4'b0100, "rtype_xor"});
      vecs.push_back('{2'b10, 4'b0101, 4'b0101, "rtype_srl"});
      vecs.push_back('{2'b10, 4'b1101, 4'b1001, "rtype_sra"});
      vecs.push_back('{2'b10, 4'b1110, 4'b0001, "rtype_or_f7"});
      vecs.push_back('{2'b10, 4'b1111, 4'b0000, "rtype_and_f7"});
      vecs.push_back('{2'b10, 4'b1100, 4'b0100, "rtype_xor_f7"});
      vecs.push_back('{2'b00, 4'b0010, 4'b0010, "ldst_add"});
      vecs.push_back('{2'b01, 4'b0000, 4'b0110, "branch_sub"});
      vecs.push_back('{2'b11, 4'b0101, 4'b1111, "nil"});

      // Reset asserted between edges forces NIL immediately.
      rst   = 1'b0;
      ALUOp = 2'b10;
      func  = 4'b0000;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkValue("reset_async_assert", 4'b1111);
      @(posedge clk);
      #1;
      checkValue("reset_hold", 4'b1111);
      @(negedge clk);
      rst = 1'b0;
      expQ.push_back(4'b0010);
      nameQ.push_back("reset_release_add");
      checkOutput();

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].exp, vecs[i].name);
         checkOutput();
      end

      for (int c = 0; c < 3; c++) begin
         logic [1:0] op;
         op       = (c == 0) ? 2'b00 : (c == 1) ? 2'b01 : 2'b11;
         sweepExp = (c == 0) ? 4'b0010 : (c == 1) ? 4'b0110 : 4'b1111;
         for (int f = 0; f < 16; f++) begin
            applyStimulus(op, f[3:0], sweepExp, $sformatf("sweep_op%0d_f%0d", op, f));
            checkOutput();
         end
      end

      // Mid-cycle input change must not reach the output before the next edge.
      applyStimulus(2'b10, 4'b0100, 4'b0100, "hold_setup_xor");
      checkOutput();
      @(negedge clk);
      ALUOp = 2'b10;
      func  = 4'b1101;
      #2;
      checkValue("hold_between_edges", 4'b0100);
      expQ.push_back(4'b1001);
      nameQ.push_back("hold_next_edge_sra");
      checkOutput();

      // Reset mid-stream discards the pending value; same inputs decode again after release.
      applyStimulus(2'b10, 4'b1000, 4'b0110, "midreset_setup_sub");
      checkOutput();
      #2;
      rst = 1'b1;
      #1;
      checkValue("midreset_async", 4'b1111);
      @(posedge clk);
      #1;
      checkValue("midreset_hold", 4'b1111);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkValue("midreset_release_no_stale", 4'b1111);
      expQ.push_back(4'b0110);
      nameQ.push_back("midreset_release_sub");
      checkOutput();

      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
